// File: rtl/instr_queue.sv
// instr_queue: circular fetch-to-decode instruction buffer with flush, async reset
// and a registered head that is presented to the decoder only when non-empty.
module instr_queue #(
    parameter int QueueDepth = 16,
    parameter int PtrLength  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_valid_from_fc,
    input  logic [31:0] pc_from_fc,
    input  logic [31:0] instr_from_fc,
    output logic        is_full_to_fc,
    input  logic        is_ready_from_issue,
    input  logic        is_clear_from_rob,
    output logic        is_empty_to_dc,
    output logic [31:0] pc_to_dc,
    output logic [31:0] instr_to_dc
);
    localparam logic [PtrLength+1:0] FullCount = (PtrLength+2)'(QueueDepth);
    logic [31:0]        r_pc    [QueueDepth];
    logic [31:0]        r_instr [QueueDepth];
    logic [PtrLength:0]   r_head;
    logic [PtrLength:0]   r_tail;
    logic [PtrLength+1:0] r_count;
    logic                 w_push;
    logic                 w_pop;
    always_comb begin
        is_full_to_fc  = r_count == FullCount;
        is_empty_to_dc = r_count == '0;
        w_push         = is_valid_from_fc && !is_full_to_fc && !is_clear_from_rob;
        w_pop          = !is_empty_to_dc && is_ready_from_issue && !is_clear_from_rob;
        pc_to_dc       = is_empty_to_dc ? 32'h0 : r_pc[r_head];
        instr_to_dc    = is_empty_to_dc ? 32'h0 : r_instr[r_head];
    end
    // Pointers are exactly log2(QueueDepth) bits wide, so wrap is free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (is_clear_from_rob) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + (PtrLength+1)'(w_pop);
            r_tail  <= r_tail + (PtrLength+1)'(w_push);
            r_count <= r_count + (PtrLength+2)'(w_push) - (PtrLength+2)'(w_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_pc[r_tail]    <= pc_from_fc;
            r_instr[r_tail] <= instr_from_fc;
        end
    end
endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: table-driven vectors plus directed sequences for fill, wrap,
// flush and asynchronous reset of instr_queue.
module tb_instr_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        is_valid_from_fc;
    logic [31:0] pc_from_fc;
    logic [31:0] instr_from_fc;
    logic        is_full_to_fc;
    logic        is_ready_from_issue;
    logic        is_clear_from_rob;
    logic        is_empty_to_dc;
    logic [31:0] pc_to_dc;
    logic [31:0] instr_to_dc;
    int checks = 0;
    int errors = 0;

    instr_queue #(.QueueDepth(16), .PtrLength(3)) dut (
        .clk(clk),
        .rst(rst),
        .is_valid_from_fc(is_valid_from_fc),
        .pc_from_fc(pc_from_fc),
        .instr_from_fc(instr_from_fc),
        .is_full_to_fc(is_full_to_fc),
        .is_ready_from_issue(is_ready_from_issue),
        .is_clear_from_rob(is_clear_from_rob),
        .is_empty_to_dc(is_empty_to_dc),
        .pc_to_dc(pc_to_dc),
        .instr_to_dc(instr_to_dc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rdy;
        logic        clr;
        logic        e_empty;
        logic        e_full;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] iw(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic idle();
        is_valid_from_fc    = 1'b0;
        is_ready_from_issue = 1'b0;
        is_clear_from_rob   = 1'b0;
    endtask

    task automatic push_n(input int n, input logic [31:0] base);
        is_ready_from_issue = 1'b0;
        for (int i = 0; i < n; i++) begin
            is_valid_from_fc = 1'b1;
            pc_from_fc       = base + 32'(i * 4);
            instr_from_fc    = iw(pc_from_fc);
            step();
        end
        is_valid_from_fc = 1'b0;
    endtask

    task automatic drain(input string name, input int n, input logic [31:0] base);
        is_valid_from_fc    = 1'b0;
        is_ready_from_issue = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk({name, "_pc"}, pc_to_dc, base + 32'(i * 4));
            chk({name, "_instr"}, instr_to_dc, iw(base + 32'(i * 4)));
            step();
        end
        chk({name, "_empty"}, 32'(is_empty_to_dc), 32'd1);
        is_ready_from_issue = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 32'h0, 32'h0050_0093, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0050_0093};
        tbl[1] = '{1'b1, 32'h4, 32'h0010_0113, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0050_0093};
        tbl[2] = '{1'b1, 32'h8, 32'h0020_81B3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0050_0093};
        tbl[3] = '{1'b0, 32'h0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0050_0093};
        tbl[4] = '{1'b0, 32'h0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h4, 32'h0010_0113};
        tbl[5] = '{1'b0, 32'h0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0020_81B3};
        tbl[6] = '{1'b0, 32'h0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
        tbl[7] = '{1'b0, 32'h0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
        tbl[8] = '{1'b1, 32'hC, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0, 32'hC, 32'h1234_5678};
        tbl[9] = '{1'b0, 32'h0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0};

        idle();
        pc_from_fc    = '0;
        instr_from_fc = '0;
        rst = 1'b1;
        #12;
        chk("rst_empty", 32'(is_empty_to_dc), 32'd1);
        chk("rst_full", 32'(is_full_to_fc), 32'd0);
        chk("rst_pc", pc_to_dc, 32'h0);
        chk("rst_instr", instr_to_dc, 32'h0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 10; i++) begin
            is_valid_from_fc    = tbl[i].v;
            pc_from_fc          = tbl[i].pc;
            instr_from_fc       = tbl[i].instr;
            is_ready_from_issue = tbl[i].rdy;
            is_clear_from_rob   = tbl[i].clr;
            step();
            chk($sformatf("vec%0d_empty", i), 32'(is_empty_to_dc), 32'(tbl[i].e_empty));
            chk($sformatf("vec%0d_full", i), 32'(is_full_to_fc), 32'(tbl[i].e_full));
            chk($sformatf("vec%0d_pc", i), pc_to_dc, tbl[i].e_pc);
            chk($sformatf("vec%0d_instr", i), instr_to_dc, tbl[i].e_instr);
        end
        idle();

        // fill to full, drop the 17th push, drain in order
        for (int i = 0; i < 16; i++) begin
            push_n(1, 32'(i * 4));
            chk($sformatf("fill%0d_full", i), 32'(is_full_to_fc), (i == 15) ? 32'd1 : 32'd0);
        end
        is_valid_from_fc = 1'b1;
        pc_from_fc       = 32'h40;
        instr_from_fc    = iw(32'h40);
        step();
        chk("drop_full", 32'(is_full_to_fc), 32'd1);
        chk("drop_head", pc_to_dc, 32'h0);
        drain("full_drain", 16, 32'h0);

        // full with simultaneous push+pop: push ignored, 15 remain
        push_n(16, 32'h0);
        is_valid_from_fc    = 1'b1;
        pc_from_fc          = 32'h100;
        instr_from_fc       = iw(32'h100);
        is_ready_from_issue = 1'b1;
        step();
        chk("fullpp_full", 32'(is_full_to_fc), 32'd0);
        chk("fullpp_head", pc_to_dc, 32'h4);
        drain("fullpp_drain", 15, 32'h4);

        // streaming through pointer wrap with occupancy held at 1
        push_n(1, 32'h0);
        is_ready_from_issue = 1'b1;
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("wrap%0d_pc", i), pc_to_dc, 32'(i * 4));
            is_valid_from_fc = 1'b1;
            pc_from_fc       = 32'((i + 1) * 4);
            instr_from_fc    = iw(pc_from_fc);
            step();
            chk($sformatf("wrap%0d_occ", i), {30'd0, is_empty_to_dc, is_full_to_fc}, 32'd0);
        end
        drain("wrap_drain", 1, 32'd160);

        // flush beats a concurrent push
        push_n(5, 32'h0);
        is_valid_from_fc  = 1'b1;
        pc_from_fc        = 32'h200;
        instr_from_fc     = iw(32'h200);
        is_clear_from_rob = 1'b1;
        step();
        chk("flush_empty", 32'(is_empty_to_dc), 32'd1);
        chk("flush_pc", pc_to_dc, 32'h0);
        idle();
        is_ready_from_issue = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("flush_post%0d", i), 32'(is_empty_to_dc), 32'd1);
        end
        idle();

        // asynchronous reset mid-cycle, then first push after release
        push_n(7, 32'h0);
        chk("prerst_head", pc_to_dc, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("arst_empty", 32'(is_empty_to_dc), 32'd1);
        chk("arst_instr", instr_to_dc, 32'h0);
        chk("arst_full", 32'(is_full_to_fc), 32'd0);
        step();
        #2 rst = 1'b0;
        is_valid_from_fc = 1'b1;
        pc_from_fc       = 32'h1000;
        instr_from_fc    = iw(32'h1000);
        step();
        chk("postrst_empty", 32'(is_empty_to_dc), 32'd0);
        drain("postrst_drain", 1, 32'h1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Parameters
REQ-001 The block SHALL have parameter QueueDepth, default 16, giving the number of entries; it SHALL be a power of two, 2..64.
REQ-002 The block SHALL have parameter PtrLength, default 3, giving the pointer MSB index (QueueDepth = 2^(PtrLength+1)).

Interface
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 is_valid_from_fc  input  1  fetch presents an instruction this cycle.
REQ-006 pc_from_fc  input  32  PC of the presented instruction.
REQ-007 instr_from_fc  input  32  raw 32-bit instruction word.
REQ-008 is_full_to_fc  output  1  queue cannot accept a push this cycle.
REQ-009 is_ready_from_issue  input  1  ROB and RS can take an issue this cycle.
REQ-010 is_clear_from_rob  input  1  mispredict or jump flush; discard all entries.
REQ-011 is_empty_to_dc  output  1  no instruction is available to the decoder.
REQ-012 pc_to_dc  output  32  PC of the head entry.
REQ-013 instr_to_dc  output  32  instruction word of the head entry.

Function
REQ-014 Storage SHALL be a circular buffer of QueueDepth {pc, instr} entries with head pointer, tail pointer and count (PtrLength+2 bits wide).
REQ-015 Push SHALL occur when is_valid_from_fc=1, count<QueueDepth and is_clear_from_rob=0; the entry SHALL be written at tail, and tail SHALL advance by 1.
REQ-016 Pop SHALL occur when count>0, is_ready_from_issue=1 and is_clear_from_rob=0; head SHALL advance by 1.
REQ-017 Pointers SHALL wrap from QueueDepth-1 to 0 with no lost or duplicated entry.
REQ-018 Count SHALL change as follows: +1 on push only, -1 on pop only, unchanged on push and pop in the same cycle.
REQ-019 is_full_to_fc SHALL equal (count==QueueDepth), combinationally from registered count.
REQ-020 When full, a push SHALL be ignored even if a pop occurs the same cycle, and the fetch word SHALL be dropped.
REQ-021 Fetch SHALL hold its word while is_full_to_fc=1.
REQ-022 is_empty_to_dc SHALL equal (count==0), combinationally from registered count.
REQ-023 pc_to_dc and instr_to_dc SHALL show the head entry whenever count>0, and SHALL be 0 when count==0.
REQ-024 Latency: a word pushed into an empty queue at edge N SHALL be visible to the decoder, with is_empty_to_dc=0, after edge N; there SHALL be no same-cycle bypass.
REQ-025 Flush SHALL take priority over push and pop: on an edge with is_clear_from_rob=1, head, tail and count SHALL become 0, and any push or pop that cycle SHALL be discarded.
REQ-026 is_empty_to_dc SHALL be 1 after a flush edge.
REQ-027 A pop SHALL NOT occur while empty, regardless of is_ready_from_issue.
REQ-028 The decoder SHALL see a stable head while is_ready_from_issue=0, with no change to pc_to_dc or instr_to_dc.

Reset
REQ-029 While rst=1, asynchronously and independently of clk, head, tail and count SHALL be 0.
REQ-030 While rst=1, is_empty_to_dc SHALL be 1, is_full_to_fc SHALL be 0, and pc_to_dc and instr_to_dc SHALL be 0.
REQ-031 Entry storage SHALL need no reset.
REQ-032 Reset asserted mid-operation SHALL discard all entries immediately.
REQ-033 After rst falls, the first push SHALL be accepted on the next rising edge.

Verification
REQ-034 Push pc=0x0, 0x4, 0x8 (instr 0x00500093, 0x00100113, 0x002081B3) with is_ready_from_issue=0, then raise ready -> decoder sees the three entries in order, one per cycle; is_empty_to_dc=1 after the third pop.
REQ-035 With ready=0, push 16 entries pc=0x0..0x3C -> is_full_to_fc=1 after the 16th edge; a 17th push pc=0x40 is dropped; draining yields exactly 0x0..0x3C.
REQ-036 Fill 16 entries, then assert push pc=0x100 and pop on the same cycle -> the push is ignored, count=15, and the head becomes pc=0x4.
REQ-037 Run continuous push+pop for 40 cycles with pc stepping by 4 -> every PC appears once in order across pointer wrap, and count stays 1.
REQ-038 Hold 5 entries, then assert is_clear_from_rob together with push pc=0x200 -> the next cycle shows is_empty_to_dc=1, pc_to_dc=0, and 0x200 is never issued.
REQ-039 Hold 7 entries, then assert rst between clock edges -> is_empty_to_dc=1 and instr_to_dc=0 without waiting for clk; after release, a push of pc=0x1000 is the first entry popped.
